idli_uart_rx_m: RTL and testbench
=================================

Name: idli_uart_rx_m

Overview:
UART receiver feeding the core from the top-level serial input, which is currently unconnected. It synchronises the RX line, deframes 8N1 characters, and buffers whole bytes in a small FIFO. Each byte is presented to the execute stage as two 4-bit nibbles, low nibble first, over a valid/accept handshake that matches the SQI/decode data width. It reports framing errors and overrun.

Parameters:
CLKS_PER_BIT, 16, core clock cycles per UART bit period; even, >= 4
BUF_DEPTH, 4, FIFO depth in bytes; power of two, >= 2

Ports:
i_urx_gck  input  1  core clock; the only clock
i_urx_rst_n  input  1  asynchronous active-low reset
i_urx_rx  input  1  raw UART RX line, asynchronous, idle high
o_urx_data  output  4  current nibble of the head byte (sqi_data_t)
o_urx_data_vld  output  1  o_urx_data holds a valid nibble
i_urx_data_acp  input  1  consumer takes the nibble this cycle
o_urx_frm_err  output  1  one-cycle pulse: stop bit sampled low
o_urx_ovr  output  1  sticky flag: a byte was dropped because the FIFO was full
i_urx_ovr_clr  input  1  clears o_urx_ovr

Behaviour:
- Reset, asynchronous: synchroniser flops = 1; FSM = IDLE; FIFO empty; nibble select = 0. Outputs on reset: o_urx_data = 0, o_urx_data_vld = 0, o_urx_frm_err = 0, o_urx_ovr = 0. Reset mid-frame discards the partial byte and all FIFO contents.
- Synchroniser: two flops on i_urx_rx. All logic uses the second flop output (rxs). Input-to-rxs latency is 2 cycles.
- Baud counter: width clog2(CLKS_PER_BIT). It counts down and "ticks" on reaching 0, then reloads CLKS_PER_BIT-1.
- FSM states:
  - IDLE: when rxs = 0, load counter with CLKS_PER_BIT/2-1 and go to START.
  - START: on tick, sample rxs. If rxs = 1 it was a glitch: go to IDLE with no output. If rxs = 0, set bit count = 0 and go to DATA.
  - DATA: on each tick, shift rxs into shreg[7] (LSB first). After 8 samples go to STOP.
  - STOP: on tick, sample rxs.
    - rxs = 1: push the byte to the FIFO and go to IDLE in the same cycle, so a back-to-back start bit is detected.
    - rxs = 0: pulse o_urx_frm_err for one cycle, discard the byte, go to BREAK.
  - BREAK: wait for rxs = 1, then go to IDLE.
- FIFO:
  - A push is accepted if occupancy < BUF_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped, FIFO contents are unchanged, and o_urx_ovr is set next cycle.
  - Read/write pointers wrap modulo BUF_DEPTH. Occupancy is held in a separate counter (0..BUF_DEPTH).
- Output side:
  - o_urx_data_vld = FIFO not empty.
  - o_urx_data = head[3:0] when nibble select = 0, head[7:4] when nibble select = 1. It is 0 when empty.
  - On vld & acp with select = 0: select becomes 1.
  - On vld & acp with select = 1: pop the FIFO and select becomes 0.
  - acp while vld = 0 is ignored.
- Latency: a byte pushed into an empty FIFO gives vld = 1 on the cycle after the stop-bit sample.
- o_urx_ovr:
  - Set by a dropped push; held until i_urx_ovr_clr.
  - When clear and a new drop occur in the same cycle, set wins.
- o_urx_data and o_urx_data_vld are stable while vld = 1 and acp = 0.

Test Plan:
1. CLKS_PER_BIT=4; send 0xA5 (8N1), acp held 1 -> nibbles 0x5 then 0xA on consecutive cycles; vld drops after the second; o_urx_frm_err stays 0.
2. Hold RX low for 1 cycle with CLKS_PER_BIT=4 (start glitch) -> FSM returns to IDLE; vld never asserts.
3. Send 0x3C with the stop bit driven 0 and RX held low a further 10 bit periods -> one frm_err pulse; no data. Release RX high, send 0x81 -> nibbles 0x1, 0x8.
4. BUF_DEPTH=4, acp=0; send 0x11, 0x22, 0x33, 0x44, 0x55 -> o_urx_ovr=1 after the 5th stop bit. Drain with acp=1 -> 1,1,2,2,3,3,4,4 (0x55 lost). Pulse i_urx_ovr_clr -> ovr=0.
5. Send two bytes 0x0F, 0xF0 back-to-back (no idle gap), acp=1 -> both received in order: F,0,0,F.
6. Assert i_urx_rst_n low during DATA of byte 0x5A with 0x12 buffered -> all outputs 0 immediately. After release, send 0x99 -> only 9,9 delivered.

Source files
------------

// File: rtl/idli_uart_rx_m.sv
// rtl/idli_uart_rx_m.sv - 8N1 UART receiver with byte FIFO and nibble-wide output handshake
module idli_uart_rx_m #(
    parameter int CLKS_PER_BIT = 16,
    parameter int BUF_DEPTH    = 4
) (
    input  logic       i_urx_gck,
    input  logic       i_urx_rst_n,
    input  logic       i_urx_rx,
    output logic [3:0] o_urx_data,
    output logic       o_urx_data_vld,
    input  logic       i_urx_data_acp,
    output logic       o_urx_frm_err,
    output logic       o_urx_ovr,
    input  logic       i_urx_ovr_clr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_HALF   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   FULL_CNT    = (AW + 1)'(BUF_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state;
    state_t          state_n;
    logic            rx_meta;
    logic            rxs;
    logic [CW-1:0]   baud_cnt;
    logic            tick;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;

    logic            ld_half;
    logic            bit_clr;
    logic            shift;
    logic            push;
    logic            frm_set;

    logic [7:0]      mem [BUF_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            nib_sel;
    logic            not_empty;
    logic            pop;
    logic            push_ok;
    logic            drop;
    logic [7:0]      head;

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
        if (!i_urx_rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= i_urx_rx;
            rxs     <= rx_meta;
        end
    end

    assign tick = (baud_cnt == '0);

    // Baud down-counter: half-period load on start edge centres later samples in each bit
    always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
        if (!i_urx_rst_n) begin
            baud_cnt <= BAUD_RELOAD;
        end else if (ld_half) begin
            baud_cnt <= BAUD_HALF;
        end else if (tick) begin
            baud_cnt <= BAUD_RELOAD;
        end else begin
            baud_cnt <= baud_cnt - 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
        if (!i_urx_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_n = state;
        ld_half = 1'b0;
        bit_clr = 1'b0;
        shift   = 1'b0;
        push    = 1'b0;
        frm_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    ld_half = 1'b1;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rxs) begin
                        state_n = S_IDLE;
                    end else begin
                        bit_clr = 1'b1;
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_n = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (rxs) begin
                        push    = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        frm_set = 1'b1;
                        state_n = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rxs) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Data bit counter and LSB-first shift register
    always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
        if (!i_urx_rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (shift) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift) begin
                shreg <= {rxs, shreg[7:1]};
            end
        end
    end

    // Framing error is a registered single-cycle pulse
    always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
        if (!i_urx_rst_n) begin
            o_urx_frm_err <= 1'b0;
        end else begin
            o_urx_frm_err <= frm_set;
        end
    end

    assign not_empty = (count != '0);
    assign pop       = not_empty && i_urx_data_acp && nib_sel;
    assign push_ok   = push && ((count != FULL_CNT) || pop);
    assign drop      = push && !push_ok;
    assign head      = mem[rd_ptr];

    // FIFO storage; contents are only meaningful below the occupancy count
    always_ff @(posedge i_urx_gck) begin
        if (push_ok) begin
            mem[wr_ptr] <= shreg;
        end
    end

    // FIFO pointers, occupancy and nibble select
    always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
        if (!i_urx_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            nib_sel <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
            if (not_empty && i_urx_data_acp) begin
                nib_sel <= ~nib_sel;
            end
        end
    end

    // Sticky overrun; a new drop takes priority over a simultaneous clear
    always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
        if (!i_urx_rst_n) begin
            o_urx_ovr <= 1'b0;
        end else if (drop) begin
            o_urx_ovr <= 1'b1;
        end else if (i_urx_ovr_clr) begin
            o_urx_ovr <= 1'b0;
        end
    end

    // Nibble output mux, forced to zero when nothing is buffered
    always_comb begin
        o_urx_data = 4'h0;
        if (not_empty) begin
            o_urx_data = nib_sel ? head[7:4] : head[3:0];
        end
    end

    assign o_urx_data_vld = not_empty;

endmodule

// File: tb/tb_idli_uart_rx_m.sv
// tb/tb_idli_uart_rx_m.sv - self-checking bench for idli_uart_rx_m
module tb_idli_uart_rx_m;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [3:0] data;
    logic       vld;
    logic       acp;
    logic       frm_err;
    logic       ovr;
    logic       ovr_clr;

    int n_cmp;
    int n_fail;
    int err_cnt;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [7:0] byte_val;
        logic       stop_bit;
        int         exp_errs;
    } vec_t;

    idli_uart_rx_m #(
        .CLKS_PER_BIT(CPB),
        .BUF_DEPTH(DEPTH)
    ) dut (
        .i_urx_gck(clk),
        .i_urx_rst_n(rst_n),
        .i_urx_rx(rx),
        .o_urx_data(data),
        .o_urx_data_vld(vld),
        .i_urx_data_acp(acp),
        .o_urx_frm_err(frm_err),
        .o_urx_ovr(ovr),
        .i_urx_ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted nibble must match the head of the expected queue
    always @(negedge clk) begin
        if (frm_err) err_cnt++;
        if (rst_n && vld && acp) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_nibble: got %0h expected none", data);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (data !== e) begin
                    n_fail++;
                    $display("FAIL nibble: got %0h expected %0h", data, e);
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic expect_byte(input logic [7:0] d);
        exp_q.push_back(d[3:0]);
        exp_q.push_back(d[7:4]);
    endtask

    task automatic wait_drain(input string name);
        int budget;
        budget = 400;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check({name, "_drain_left"}, exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        check({name, "_vld_after"}, vld, 0);
    endtask

    vec_t vecs[6];

    initial begin
        vec_t v;
        int   err_base;
        clk = 0; rst_n = 0; rx = 1; acp = 0; ovr_clr = 0;
        n_cmp = 0; n_fail = 0; err_cnt = 0;

        vecs[0] = '{8'hA5, 1'b1, 0};
        vecs[1] = '{8'h3C, 1'b0, 1};
        vecs[2] = '{8'h81, 1'b1, 0};
        vecs[3] = '{8'h00, 1'b1, 0};
        vecs[4] = '{8'hFF, 1'b1, 0};
        vecs[5] = '{8'h6E, 1'b1, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", vld, 0);
        check("rst_data", data, 0);
        check("rst_frm_err", frm_err, 0);
        check("rst_ovr", ovr, 0);
        rst_n = 1;
        repeat (4) @(posedge clk);
        #1;

        // Table-driven frames with acp held high
        acp = 1;
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            err_base = err_cnt;
            if (v.stop_bit) expect_byte(v.byte_val);
            send_frame(v.byte_val, v.stop_bit);
            if (!v.stop_bit) begin
                repeat (10) drive_bit(1'b0);
                drive_bit(1'b1);
            end
            wait_drain($sformatf("vec%0d", i));
            drive_bit(1'b1);
            drive_bit(1'b1);
            check($sformatf("vec%0d_frm_err", i), err_cnt - err_base, v.exp_errs);
        end

        // Start-bit glitch: one low cycle is rejected
        err_base = err_cnt;
        rx = 0;
        @(posedge clk);
        #1;
        rx = 1;
        repeat (4) drive_bit(1'b1);
        check("glitch_vld", vld, 0);
        check("glitch_frm_err", err_cnt - err_base, 0);

        // Overrun: fill four, drop the fifth
        acp = 0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        drive_bit(1'b1);
        check("ovr_before_full", ovr, 0);
        send_frame(8'h55, 1'b1);
        drive_bit(1'b1);
        check("ovr_after_drop", ovr, 1);
        check("hold_vld", vld, 1);
        check("hold_data_a", data, 4'h1);
        repeat (3) @(posedge clk);
        #1;
        check("hold_data_b", data, 4'h1);
        expect_byte(8'h11);
        expect_byte(8'h22);
        expect_byte(8'h33);
        expect_byte(8'h44);
        acp = 1;
        wait_drain("ovr");
        check("ovr_sticky", ovr, 1);
        ovr_clr = 1;
        @(posedge clk);
        #1;
        ovr_clr = 0;
        check("ovr_cleared", ovr, 0);

        // Back-to-back frames with no idle gap
        expect_byte(8'h0F);
        expect_byte(8'hF0);
        send_frame(8'h0F, 1'b1);
        send_frame(8'hF0, 1'b1);
        wait_drain("b2b");

        // Reset mid-frame with a byte buffered
        acp = 0;
        send_frame(8'h12, 1'b1);
        drive_bit(1'b1);
        check("pre_rst_vld", vld, 1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst_n = 0;
        #1;
        check("mid_rst_vld", vld, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_frm_err", frm_err, 0);
        check("mid_rst_ovr", ovr, 0);
        rx = 1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_vld", vld, 0);
        acp = 1;
        expect_byte(8'h99);
        send_frame(8'h99, 1'b1);
        wait_drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
